// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one result bit per cycle.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int EXC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [EXC_W-1:0] exception_code,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [EXC_W-1:0]   exc_q, exc_d;
    logic               rdy_q;
    logic               capture;

    logic [2*XLEN-1:0]  acc_q, acc_nxt;
    logic [XLEN-1:0]    m_q;
    logic [2:0]         f3_q;
    logic               neg_q, neg_r_q;

    logic               legal, div_zero, div_ovf;
    logic               a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]    mag_a, mag_b;

    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   m);
        logic [XLEN:0] sum;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {sum, acc[XLEN-1:1]};
    endfunction

    // Remainder lives in the upper half, quotient bits shift in at the bottom.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   m);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = acc[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, m};
        if (sh >= {1'b0, m})
            return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            return {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc,
                                              input logic [2:0]        f3,
                                              input logic              neg,
                                              input logic              neg_r);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg   ? -acc : acc;
        quo  = neg   ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quo;
            default:                return rem;
        endcase
    endfunction

    assign legal    = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                      (op_a == MOST_NEG) && (op_b == '1);

    assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed = a_signed && (funct3 != 3'b010);
    assign sa       = a_signed && op_a[XLEN-1];
    assign sb       = b_signed && op_b[XLEN-1];
    assign mag_a    = sa ? -op_a : op_a;
    assign mag_b    = sb ? -op_b : op_b;

    assign acc_nxt  = f3_q[2] ? div_step(acc_q, m_q) : mul_step(acc_q, m_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        capture  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && rdy_q) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        exc_d   = '0;
                        if (!legal) begin
                            state_d  = DONE;
                            result_d = '0;
                            exc_d    = EXC_W'(1);
                        end else if (div_zero) begin
                            state_d  = DONE;
                            result_d = funct3[1] ? op_a : '1;
                        end else if (div_ovf) begin
                            state_d  = DONE;
                            result_d = funct3[1] ? '0 : op_a;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = fixup(acc_nxt, f3_q, neg_q, neg_r_q);
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand magnitudes and sign fix-up flags are latched at accept time.
    always_ff @(posedge clk) begin
        if (capture) begin
            f3_q    <= funct3;
            acc_q   <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            m_q     <= funct3[2] ? mag_b : mag_a;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
        end else if (state_q == CALC) begin
            acc_q   <= acc_nxt;
        end
    end

    assign in_ready       = (state_q == IDLE) && rdy_q;
    assign out_valid      = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign result         = result_q;
    assign exception_code = exc_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: 32-bit instance for function, handshake and
// abort paths, plus a 16-bit instance for parametrisation.
module tb_mul_div_unit;

    localparam logic [6:0] OPC = 7'b0110011;
    localparam logic [6:0] F7  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result, exception_code;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_busy;
    logic [6:0]  s_opcode, s_funct7;
    logic [2:0]  s_funct3;
    logic [15:0] s_op_a, s_op_b, s_result;
    logic [7:0]  s_exc;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32), .EXC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .exception_code(exception_code), .busy(busy)
    );

    mul_div_unit #(.XLEN(16), .EXC_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .opcode(s_opcode), .funct7(s_funct7), .funct3(s_funct3), .op_a(s_op_a),
        .op_b(s_op_b), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .exception_code(s_exc), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode = opc; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; funct3 = ~f3;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovld_low"}, out_valid, 1'b0);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int l;
        start_op(OPC, F7, f3, a, b);
        wait_out(l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_exc"}, exception_code, 32'd0);
        release_out(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        opcode = OPC; funct7 = F7; funct3 = 3'b000; op_a = '0; op_b = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        s_opcode = OPC; s_funct7 = F7; s_funct3 = 3'b000; s_op_a = '0; s_op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovld", out_valid, 1'b0);
        chk("rst_res", result, 32'd0);
        chk("rst_exc", exception_code, 32'd0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_inrdy", in_ready, 1'b1);

        run_op("mul_42x-3", 3'b000, 32'd42, 32'hFFFF_FFFD, 32'hFFFF_FF82, 33);
        run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
        run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_by0", 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 3'b111, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Back-pressure: result held while the consumer stalls.
        start_op(OPC, F7, 3'b000, 32'd5, 32'd6);
        wait_out(lat);
        chk("bp_lat", lat, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_res", result, 32'd30);
            chk("bp_inrdy", in_ready, 1'b0);
            chk("bp_ovld", out_valid, 1'b1);
        end
        release_out("bp");

        // Flush in CALC, with a competing request on the same edge.
        start_op(OPC, F7, 3'b000, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_ovld", out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_ovld", seen, 1'b0);

        // Flush in IDLE blocks an accept on the same edge.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_busy", busy, 1'b0);

        // Asynchronous reset mid-CALC discards the operation.
        start_op(OPC, F7, 3'b000, 32'd7, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ovld", out_valid, 1'b0);
        chk("rstmid_res", result, 32'd0);
        chk("rstmid_exc", exception_code, 32'd0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_inrdy", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid_no_ovld", seen, 1'b0);

        // Illegal opcode.
        start_op(7'b1100001, F7, 3'b000, 32'd3, 32'd4);
        wait_out(lat);
        chk("ill_lat", lat, 1);
        chk("ill_exc", exception_code, 32'd1);
        chk("ill_res", result, 32'd0);
        release_out("ill");

        // 16-bit instance: 300*300 = 0x15F90.
        @(negedge clk);
        s_funct3 = 3'b000; s_op_a = 16'd300; s_op_b = 16'd300; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("x16_lat", lat, 17);
        chk("x16_res", s_result, 16'h5F90);
        chk("x16_exc", s_exc, 8'd0);
        @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        chk("x16_ovld_low", s_out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
